// File: rtl/mux_n_pipe.sv
// N-channel, W-bit multiplexer with one registered output stage and valid/ready on every port.
// Channel choice is either a fixed index (mode=0) or round-robin after the last granted channel (mode=1).
module mux_n_pipe #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0] outData_q, outData_d;
    logic [SEL_W-1:0] outChan_q, outChan_d;
    logic [SEL_W-1:0] rrLast_q, rrLast_d;
    logic             outValid_q, outValid_d;
    logic [SEL_W-1:0] grantIdx;
    logic             grantValid;
    logic             load;
    logic             xfer;
    int               rrIdx;

    assign load = !outValid_q || out_ready;
    assign xfer = grantValid && load;

    // An out-of-range sel simply never matches any channel index.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        rrIdx      = 0;
        if (!mode) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (int'(sel) == i && in_valid[i]) begin
                    grantValid = 1'b1;
                    grantIdx   = SEL_W'(i);
                end
            end
        end else begin
            for (int k = 1; k <= CHANNELS; k++) begin
                rrIdx = (int'(rrLast_q) + k) % CHANNELS;
                if (!grantValid && in_valid[rrIdx]) begin
                    grantValid = 1'b1;
                    grantIdx   = SEL_W'(rrIdx);
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = rst_n && xfer && (int'(grantIdx) == i);
        end
    end

    always_comb begin
        outData_d  = outData_q;
        outChan_d  = outChan_q;
        outValid_d = outValid_q;
        rrLast_d   = rrLast_q;
        if (xfer) begin
            outData_d  = in_data[int'(grantIdx)*WIDTH +: WIDTH];
            outChan_d  = grantIdx;
            outValid_d = 1'b1;
            if (mode) begin
                rrLast_d = grantIdx;
            end
        end else if (outValid_q && out_ready) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outData_q  <= '0;
            outChan_q  <= '0;
            outValid_q <= 1'b0;
            rrLast_q   <= SEL_W'(CHANNELS - 1);
        end else begin
            outData_q  <= outData_d;
            outChan_q  <= outChan_d;
            outValid_q <= outValid_d;
            rrLast_q   <= rrLast_d;
        end
    end

    assign out_data  = outData_q;
    assign out_chan  = outChan_q;
    assign out_valid = outValid_q;

endmodule
